// File: rtl/testdata_pkg.sv
// Shared constants and state type for the DDR3 test-data generator/checker pair.
package testdata_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2,
    TOUT  = 2'd3
  } state_t;

  // Generator and checker both default to these so the sequence lengths agree.
  localparam int DEF_TOTAL_NUM = 1300;
  localparam int DEF_START_VAL = 0;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/testdata_check_if.sv
// Read-FIFO side signals observed by the test-data checker.
interface testdata_check_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rd_mem_enable;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output rd_mem_enable, output rd_en, output rd_data);
  modport slave  (input  rd_mem_enable, input  rd_en, input  rd_data);
endinterface

// File: rtl/testdata_vld_dly.sv
// Delays the read-FIFO read enable by the FIFO read latency to mark valid data.
module testdata_vld_dly #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  output logic data_vld
);

  logic [RD_LATENCY-1:0] sr_q;

  generate
    if (RD_LATENCY == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= rd_en;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[RD_LATENCY-2:0], rd_en};
      end
    end
  endgenerate

  assign data_vld = sr_q[RD_LATENCY-1];

endmodule

// File: rtl/testdata_check.sv
// Checks read-FIFO words against the incrementing test sequence and reports
// completion, pass/fail, stall timeout and overrun.
//
// state | meaning
// IDLE  | waiting for rd_mem_enable to arm
// CHECK | comparing each valid word, watching for stalls
// DONE  | TOTAL_NUM words checked; extra words flag overrun
// TOUT  | stall detected; everything frozen until reset
module testdata_check
  import testdata_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_NUM   = DEF_TOTAL_NUM,
  parameter int START_VAL   = DEF_START_VAL,
  parameter int RD_LATENCY  = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  testdata_check_if.slave       rd_if,
  output logic [CNT_WIDTH-1:0]  rx_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  check_done,
  output logic                  check_pass,
  output logic                  timeout,
  output logic                  overrun
);

  localparam int                    TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_WIDTH-1:0]  TOTAL_C  = CNT_WIDTH'(TOTAL_NUM);
  localparam logic [DATA_WIDTH-1:0] START_C  = DATA_WIDTH'(START_VAL);
  localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(TIMEOUT_CYC);

  generate
    if (TOTAL_NUM < 1 || longint'(TOTAL_NUM) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_total
      $error("testdata_check: TOTAL_NUM out of range for CNT_WIDTH");
    end
    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
      $error("testdata_check: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  state_t                state_q, state_d;
  logic                  data_vld;
  logic                  chk_vld;
  logic                  word_ok;
  logic                  last_word;
  logic                  tmr_tc;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [TMR_W-1:0]      tmr_q;

  testdata_vld_dly #(.RD_LATENCY(RD_LATENCY)) u_vld_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_if.rd_en),
    .data_vld (data_vld)
  );

  assign chk_vld   = (state_q == CHECK) && data_vld;
  assign word_ok   = (rd_if.rd_data == exp_q);
  assign last_word = (rx_cnt == TOTAL_C - 1'b1);
  assign tmr_tc    = (tmr_q == TMR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A valid word in the terminal-count cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rd_if.rd_mem_enable) state_d = CHECK;
      CHECK: begin
        if (data_vld) begin
          if (last_word) state_d = DONE;
        end else if (tmr_tc) begin
          state_d = TOUT;
        end
      end
      DONE:    state_d = DONE;
      TOUT:    state_d = TOUT;
      default: state_d = IDLE;
    endcase
  end

  // Stall timer: reloaded on arming and on every valid word, counts down otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               tmr_q <= '0;
    else if (state_q == IDLE || chk_vld)      tmr_q <= TMR_LOAD;
    else if (state_q == CHECK)                tmr_q <= tmr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q          <= START_C;
      rx_cnt         <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      check_done     <= 1'b0;
      check_pass     <= 1'b0;
      timeout        <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (chk_vld) begin
        exp_q  <= exp_q + 1'b1;
        rx_cnt <= rx_cnt + 1'b1;
        if (!word_ok) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          // err_cnt never returns to zero, so this captures only the first miss.
          if (err_cnt == '0) begin
            first_err_idx  <= rx_cnt;
            first_err_data <= rd_if.rd_data;
          end
        end
      end
      if (state_q == CHECK && state_d == DONE) begin
        check_done <= 1'b1;
        check_pass <= word_ok && (err_cnt == '0);
      end
      if (state_q == CHECK && state_d == TOUT) timeout <= 1'b1;
      if (state_q == DONE && data_vld)         overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_testdata_check.sv
// Directed bench for testdata_check: three instances cover latency 1/2, 8-bit wrap and stall.
module tb_testdata_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en_v;
  logic [15:0] rd_data_v;
  logic        en_a, en_b, en_c;

  always #5 clk = ~clk;

  testdata_check_if #(.DATA_WIDTH(16)) if_a ();
  testdata_check_if #(.DATA_WIDTH(8))  if_b ();
  testdata_check_if #(.DATA_WIDTH(16)) if_c ();

  assign if_a.rd_mem_enable = en_a;
  assign if_a.rd_en         = rd_en_v;
  assign if_a.rd_data       = rd_data_v;
  assign if_b.rd_mem_enable = en_b;
  assign if_b.rd_en         = rd_en_v;
  assign if_b.rd_data       = rd_data_v[7:0];
  assign if_c.rd_mem_enable = en_c;
  assign if_c.rd_en         = rd_en_v;
  assign if_c.rd_data       = rd_data_v;

  logic [15:0] rx_a, err_a, idx_a, fed_a;
  logic [15:0] rx_b, err_b, idx_b;
  logic [7:0]  fed_b;
  logic [15:0] rx_c, err_c, idx_c, fed_c;
  logic        done_a, pass_a, tout_a, ovr_a;
  logic        done_b, pass_b, tout_b, ovr_b;
  logic        done_c, pass_c, tout_c, ovr_c;

  testdata_check #(.DATA_WIDTH(16), .TOTAL_NUM(1300), .START_VAL(0), .RD_LATENCY(1),
                   .CNT_WIDTH(16), .TIMEOUT_CYC(50)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_if(if_a), .rx_cnt(rx_a), .err_cnt(err_a),
    .first_err_idx(idx_a), .first_err_data(fed_a), .check_done(done_a),
    .check_pass(pass_a), .timeout(tout_a), .overrun(ovr_a));

  testdata_check #(.DATA_WIDTH(8), .TOTAL_NUM(10), .START_VAL(250), .RD_LATENCY(1),
                   .CNT_WIDTH(16), .TIMEOUT_CYC(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_if(if_b), .rx_cnt(rx_b), .err_cnt(err_b),
    .first_err_idx(idx_b), .first_err_data(fed_b), .check_done(done_b),
    .check_pass(pass_b), .timeout(tout_b), .overrun(ovr_b));

  testdata_check #(.DATA_WIDTH(16), .TOTAL_NUM(1300), .START_VAL(0), .RD_LATENCY(2),
                   .CNT_WIDTH(16), .TIMEOUT_CYC(100000)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_if(if_c), .rx_cnt(rx_c), .err_cnt(err_c),
    .first_err_idx(idx_c), .first_err_data(fed_c), .check_done(done_c),
    .check_pass(pass_c), .timeout(tout_c), .overrun(ovr_c));

  int          n_chk = 0;
  int          n_err = 0;
  int          lat = 1;
  int          start_v = 0;
  logic [15:0] mask = 16'hFFFF;
  logic [15:0] d1, d2;
  int          bad_idx0, bad_idx1;
  logic [15:0] bad_val0, bad_val1;
  bit          gaps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the modelled read FIFO: data appears lat cycles after its rd_en.
  task automatic step(input logic en, input logic [15:0] w);
    rd_en_v   = en;
    rd_data_v = (lat == 1) ? d1 : d2;
    d2 = d1;
    d1 = w;
    tick();
  endtask

  function automatic logic [15:0] word(input int k);
    if (k == bad_idx0) return bad_val0;
    if (k == bad_idx1) return bad_val1;
    return 16'(start_v + k) & mask;
  endfunction

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) step(1'b0, 16'h0);
      step(1'b1, word(k));
    end
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rd_en_v = 1'b0; rd_data_v = '0; d1 = '0; d2 = '0;
    bad_idx0 = -1; bad_idx1 = -1; bad_val0 = '0; bad_val1 = '0; gaps = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    do_reset();
    check("rst_rx", rx_a, 0);
    check("rst_err", err_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_tout", tout_a, 0);
    check("rst_ovr", ovr_a, 0);

    // Clean run; rd_mem_enable drops right after arming.
    en_a = 1'b1; step(1'b0, 16'h0); en_a = 1'b0;
    feed(1300);
    check("clean_pre_done", done_a, 0);
    check("clean_pre_rx", rx_a, 1299);
    flush(1);
    check("clean_rx", rx_a, 1300);
    check("clean_err", err_a, 0);
    check("clean_done", done_a, 1);
    check("clean_pass", pass_a, 1);
    check("clean_tout", tout_a, 0);
    check("clean_ovr", ovr_a, 0);

    // Single corruption at index 500.
    do_reset();
    bad_idx0 = 500; bad_val0 = 16'h1234;
    en_a = 1'b1; step(1'b0, 16'h0);
    feed(1300); flush(1);
    check("one_err", err_a, 1);
    check("one_idx", idx_a, 500);
    check("one_data", fed_a, 16'h1234);
    check("one_done", done_a, 1);
    check("one_pass", pass_a, 0);

    // Two errors with random idle gaps.
    do_reset();
    bad_idx0 = 10; bad_val0 = 16'hBEEF;
    bad_idx1 = 20; bad_val1 = 16'hDEAD;
    gaps = 1'b1;
    en_a = 1'b1; step(1'b0, 16'h0);
    feed(1300); flush(1);
    check("gap_err", err_a, 2);
    check("gap_idx", idx_a, 10);
    check("gap_data", fed_a, 16'hBEEF);
    check("gap_done", done_a, 1);
    check("gap_pass", pass_a, 0);
    check("gap_tout", tout_a, 0);

    // Stall after 700 words, timeout limit 50.
    do_reset();
    en_a = 1'b1; step(1'b0, 16'h0);
    feed(700);
    step(1'b0, 16'h0);
    check("stall_rx_pre", rx_a, 700);
    check("stall_tout_pre", tout_a, 0);
    k = 0;
    while (!tout_a && k < 200) begin
      step(1'b0, 16'h0);
      k++;
    end
    check("stall_cycles", k, 50);
    check("stall_tout", tout_a, 1);
    check("stall_done", done_a, 0);
    feed(5); flush(2);
    check("stall_rx_frozen", rx_a, 700);
    check("stall_err_frozen", err_a, 0);
    check("stall_ovr", ovr_a, 0);

    // 8-bit wrap 250..255,0..3 then an extra word.
    do_reset();
    start_v = 250; mask = 16'h00FF;
    en_b = 1'b1; step(1'b0, 16'h0);
    feed(10); flush(1);
    check("wrap_rx", rx_b, 10);
    check("wrap_err", err_b, 0);
    check("wrap_idx", idx_b, 0);
    check("wrap_fed", fed_b, 0);
    check("wrap_done", done_b, 1);
    check("wrap_pass", pass_b, 1);
    check("wrap_ovr_pre", ovr_b, 0);
    step(1'b1, word(10)); flush(1);
    check("wrap_ovr", ovr_b, 1);
    check("wrap_rx_frozen", rx_b, 10);
    check("wrap_tout", tout_b, 0);

    // Latency 2 clean run.
    do_reset();
    start_v = 0; mask = 16'hFFFF; lat = 2;
    en_c = 1'b1; step(1'b0, 16'h0);
    feed(1300); flush(1);
    check("lat2_pre_done", done_c, 0);
    check("lat2_pre_rx", rx_c, 1299);
    flush(1);
    check("lat2_rx", rx_c, 1300);
    check("lat2_done", done_c, 1);
    check("lat2_pass", pass_c, 1);

    // Reset mid-run at word 300, then a fresh run.
    do_reset();
    en_c = 1'b1; step(1'b0, 16'h0);
    bad_idx0 = 5; bad_val0 = 16'h00AA;
    feed(300);
    check("mid_rx_pre", rx_c, 298);
    check("mid_err_pre", err_c, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rx", rx_c, 0);
    check("mid_err", err_c, 0);
    check("mid_idx", idx_c, 0);
    check("mid_fed", fed_c, 0);
    check("mid_done", done_c, 0);
    check("mid_pass", pass_c, 0);
    check("mid_tout", tout_c, 0);
    check("mid_ovr", ovr_c, 0);
    rd_en_v = 1'b0; d1 = '0; d2 = '0; bad_idx0 = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    en_c = 1'b1; step(1'b0, 16'h0); en_c = 1'b0;
    feed(1300); flush(2);
    check("rerun_rx", rx_c, 1300);
    check("rerun_err", err_c, 0);
    check("rerun_done", done_c, 1);
    check("rerun_pass", pass_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
